// File: rtl/delay_monitor_pkg.sv
// Shared types, defaults and elaboration helpers
// for the delay pulse monitor.
package delay_pkg;

  typedef enum logic {
    SYNC,
    CHECK
  } mon_state_t;

  localparam int N_DEF     = 7500;
  localparam int CBITS_DEF = 13;
  localparam int TOL_DEF   = 2;
  localparam int LOCKN_DEF = 4;

  function automatic bit width_ok(
    input int cbits,
    input int n,
    input int tol
  );
    return (longint'(1) << cbits) > longint'(n + tol);
  endfunction

endpackage

// File: rtl/delay_monitor_if.sv
// Strobe input and status outputs of the delay monitor.
// The generator/observer side is master, the monitor is slave.
interface delay_monitor_if #(
  parameter int CBITS = delay_pkg::CBITS_DEF
);
  logic             sig;
  logic             locked;
  logic             early;
  logic             late;
  logic             err;
  logic [CBITS-1:0] last_period;
  logic [7:0]       fault_cnt;

  modport master (
    output sig,
    input  locked, early, late, err,
    input  last_period, fault_cnt
  );

  modport slave (
    input  sig,
    output locked, early, late, err,
    output last_period, fault_cnt
  );
endinterface

// File: rtl/delay_monitor_sat_counter.sv
// Up counter that sticks at MAX; clr wins over inc.
module sat_counter #(
  parameter int WIDTH = 8,
  parameter int MAX   = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && q != WIDTH'(MAX)) begin
      q <= q + 1'b1;
    end
  end
endmodule

// File: rtl/delay_monitor.sv
// Checks the interval between sig strobes against N +/- TOL,
// flags early/late faults and reports lock.
module delay_monitor
  import delay_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int CBITS = CBITS_DEF,
  parameter int TOL   = TOL_DEF,
  parameter int LOCKN = LOCKN_DEF
) (
  input logic             clk,
  input logic             rst,
  delay_monitor_if.slave  bus
);
  localparam int GW = $clog2(LOCKN + 1);
  localparam logic [CBITS-1:0] LO = CBITS'(N - TOL);
  localparam logic [CBITS-1:0] HI = CBITS'(N + TOL);

  if (!width_ok(CBITS, N, TOL)) begin : g_bad_width
    $error("CBITS too narrow for N+TOL");
  end

  mon_state_t       state;
  logic [CBITS-1:0] cnt;
  logic [GW-1:0]    good_cnt;
  logic             in_check;
  logic             accept;
  logic             early_f;
  logic             late_f;
  logic             fault;

  assign in_check = (state == CHECK);
  // cnt tops out at HI, so the window needs only a lower bound
  assign accept   = in_check && bus.sig && cnt >= LO;
  assign early_f  = in_check && bus.sig && cnt < LO;
  assign late_f   = in_check && !bus.sig && cnt == HI;
  assign fault    = early_f || late_f;

  sat_counter #(
    .WIDTH (GW),
    .MAX   (LOCKN)
  ) u_good (
    .clk (clk),
    .rst (rst),
    .inc (accept),
    .clr (fault),
    .q   (good_cnt)
  );

  sat_counter #(
    .WIDTH (8),
    .MAX   (255)
  ) u_fault (
    .clk (clk),
    .rst (rst),
    .inc (fault),
    .clr (1'b0),
    .q   (bus.fault_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= SYNC;
      cnt             <= '0;
      bus.locked      <= 1'b0;
      bus.early       <= 1'b0;
      bus.late        <= 1'b0;
      bus.err         <= 1'b0;
      bus.last_period <= '0;
    end else begin
      bus.early <= early_f;
      bus.late  <= late_f;
      bus.err   <= fault;
      // locked mirrors good_cnt == LOCKN after this edge
      if (bus.locked) begin
        bus.locked <= !fault;
      end else begin
        bus.locked <= accept &&
                      good_cnt == GW'(LOCKN - 1);
      end
      unique case (state)
        SYNC: begin
          cnt <= '0;
          if (bus.sig) begin
            state <= CHECK;
          end
        end
        CHECK: begin
          unique case (1'b1)
            accept, early_f: begin
              cnt             <= '0;
              bus.last_period <= cnt;
            end
            late_f: begin
              cnt   <= '0;
              state <= SYNC;
            end
            default: cnt <= cnt + 1'b1;
          endcase
        end
        default: begin
          state <= SYNC;
          cnt   <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_delay_monitor.sv
// Self-checking bench for delay_monitor at N=10, TOL=1, LOCKN=2
// with a period-level reference model.
module tb_delay_monitor;
  localparam int N     = 10;
  localparam int TOL   = 1;
  localparam int LOCKN = 2;
  localparam int CB    = 4;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  // reference model: period-level view of the link
  bit m_anch;
  int m_since;
  int m_good;
  int m_fault;
  int m_last;
  bit m_early;
  bit m_late;

  // observed pulse counters
  int n_early;
  int n_late;
  int n_err;
  int n_both;

  delay_monitor_if #(.CBITS(CB)) bus();

  delay_monitor #(
    .N     (N),
    .CBITS (CB),
    .TOL   (TOL),
    .LOCKN (LOCKN)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step(input logic s, input logic r);
    bus.sig = s;
    rst     = r;
    @(posedge clk);
    #1;
    if (r) begin
      m_anch  = 0;
      m_since = 0;
      m_good  = 0;
      m_fault = 0;
      m_last  = 0;
      m_early = 0;
      m_late  = 0;
    end else begin
      m_early = 0;
      m_late  = 0;
      if (!m_anch) begin
        if (s) begin
          m_anch  = 1;
          m_since = 0;
        end
      end else begin
        m_since++;
        if (s) begin
          m_last = m_since - 1;
          if (m_since >= N - TOL + 1) begin
            if (m_good < LOCKN) m_good++;
          end else begin
            m_good  = 0;
            m_early = 1;
            if (m_fault < 255) m_fault++;
          end
          m_since = 0;
        end else if (m_since == N + TOL + 1) begin
          m_anch = 0;
          m_good = 0;
          m_late = 1;
          if (m_fault < 255) m_fault++;
        end
      end
    end
    if (bus.early) n_early++;
    if (bus.late) n_late++;
    if (bus.err) n_err++;
    if (bus.early && bus.late) n_both++;
  endtask

  task automatic gap(input int g);
    for (int i = 1; i < g; i++) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
  endtask

  task automatic test_reset;
    repeat (3) step(1'b0, 1'b1);
    total++;
    if (bus.locked !== 1'b0) begin
      bad++;
      $display("FAIL rst_locked got=%b exp=0", bus.locked);
    end
    total++;
    if ({bus.early, bus.late, bus.err} !== 3'b000) begin
      bad++;
      $display("FAIL rst_flags got=%b%b%b exp=000",
               bus.early, bus.late, bus.err);
    end
    total++;
    if (bus.last_period !== 4'd0) begin
      bad++;
      $display("FAIL rst_last got=%0d exp=0", bus.last_period);
    end
    total++;
    if (bus.fault_cnt !== 8'd0) begin
      bad++;
      $display("FAIL rst_fault got=%0d exp=0", bus.fault_cnt);
    end
  endtask

  task automatic test_nominal;
    int e0;
    e0 = n_err;
    repeat (4) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    gap(11);
    total++;
    if (bus.locked !== 1'b0 || bus.last_period !== 4'd10) begin
      bad++;
      $display("FAIL nom_s2 got=%b/%0d exp=0/10",
               bus.locked, bus.last_period);
    end
    gap(11);
    total++;
    if (bus.locked !== 1'b1) begin
      bad++;
      $display("FAIL nom_lock got=%b exp=1", bus.locked);
    end
    gap(11);
    gap(11);
    total++;
    if (bus.locked !== 1'b1 || bus.last_period !== 4'd10) begin
      bad++;
      $display("FAIL nom_hold got=%b/%0d exp=1/10",
               bus.locked, bus.last_period);
    end
    total++;
    if (n_err != e0) begin
      bad++;
      $display("FAIL nom_err got=%0d exp=0", n_err - e0);
    end
  endtask

  task automatic test_window;
    gap(10);
    total++;
    if (bus.last_period !== 4'd9 || bus.locked !== 1'b1 ||
        bus.early !== 1'b0) begin
      bad++;
      $display("FAIL win_lo got=%0d/%b/%b exp=9/1/0",
               bus.last_period, bus.locked, bus.early);
    end
    gap(12);
    total++;
    if (bus.last_period !== 4'd11 || bus.locked !== 1'b1 ||
        bus.late !== 1'b0) begin
      bad++;
      $display("FAIL win_hi got=%0d/%b/%b exp=11/1/0",
               bus.last_period, bus.locked, bus.late);
    end
    gap(9);
    total++;
    if (bus.early !== 1'b1 || bus.err !== 1'b1 ||
        bus.locked !== 1'b0) begin
      bad++;
      $display("FAIL win_early got=e%b r%b l%b exp=e1 r1 l0",
               bus.early, bus.err, bus.locked);
    end
    total++;
    if (bus.fault_cnt !== 8'd1 || bus.last_period !== 4'd8) begin
      bad++;
      $display("FAIL win_fault got=%0d/%0d exp=1/8",
               bus.fault_cnt, bus.last_period);
    end
    step(1'b0, 1'b0);
    total++;
    if (bus.early !== 1'b0) begin
      bad++;
      $display("FAIL win_pulse got=%b exp=0", bus.early);
    end
  endtask

  task automatic test_late;
    int at;
    int l0;
    gap(10);
    gap(11);
    total++;
    if (bus.locked !== 1'b1) begin
      bad++;
      $display("FAIL late_pre got=%b exp=1", bus.locked);
    end
    at = 0;
    l0 = n_late;
    for (int k = 1; k <= 20; k++) begin
      step(1'b0, 1'b0);
      if (bus.late && at == 0) at = k;
    end
    total++;
    if (at != N + TOL + 1) begin
      bad++;
      $display("FAIL late_when got=%0d exp=%0d", at, N + TOL + 1);
    end
    total++;
    if (n_late - l0 != 1 || bus.locked !== 1'b0) begin
      bad++;
      $display("FAIL late_once got=%0d/%b exp=1/0",
               n_late - l0, bus.locked);
    end
    total++;
    if (bus.fault_cnt !== 8'd2) begin
      bad++;
      $display("FAIL late_fault got=%0d exp=2", bus.fault_cnt);
    end
    gap(5);
    total++;
    if (bus.early !== 1'b0 || bus.fault_cnt !== 8'd2 ||
        bus.last_period !== 4'd10) begin
      bad++;
      $display("FAIL late_anchor got=%b/%0d/%0d exp=0/2/10",
               bus.early, bus.fault_cnt, bus.last_period);
    end
    gap(11);
    total++;
    if (bus.locked !== 1'b0) begin
      bad++;
      $display("FAIL late_relock1 got=%b exp=0", bus.locked);
    end
    gap(11);
    total++;
    if (bus.locked !== 1'b1) begin
      bad++;
      $display("FAIL late_relock2 got=%b exp=1", bus.locked);
    end
  endtask

  task automatic test_reset_mid;
    repeat (6) step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    total++;
    if ({bus.locked, bus.early, bus.late, bus.err} !== 4'b0000 ||
        bus.last_period !== 4'd0 || bus.fault_cnt !== 8'd0) begin
      bad++;
      $display("FAIL rmid_vals got=%b%b%b%b/%0d/%0d exp=0000/0/0",
               bus.locked, bus.early, bus.late, bus.err,
               bus.last_period, bus.fault_cnt);
    end
    gap(3);
    gap(11);
    total++;
    if (bus.locked !== 1'b0 || bus.fault_cnt !== 8'd0) begin
      bad++;
      $display("FAIL rmid_s2 got=%b/%0d exp=0/0",
               bus.locked, bus.fault_cnt);
    end
    gap(11);
    total++;
    if (bus.locked !== 1'b1) begin
      bad++;
      $display("FAIL rmid_lock got=%b exp=1", bus.locked);
    end
  endtask

  task automatic test_random;
    int g;
    bit r;
    for (int n = 0; n < 60; n++) begin
      g = int'($urandom_range(4, 15));
      for (int i = 1; i <= g; i++) begin
        r = ($urandom_range(0, 99) == 0);
        step(i == g, r);
        total++;
        if (bus.locked !== (m_good == LOCKN) ||
            bus.early !== m_early || bus.late !== m_late ||
            bus.err !== (m_early | m_late) ||
            bus.last_period !== CB'(m_last) ||
            bus.fault_cnt !== 8'(m_fault)) begin
          bad++;
          $display("FAIL rnd n=%0d got=%b%b%b%b/%0d/%0d exp=%b%b%b%b/%0d/%0d",
                   n, bus.locked, bus.early, bus.late, bus.err,
                   bus.last_period, bus.fault_cnt,
                   m_good == LOCKN, m_early, m_late,
                   m_early | m_late, m_last, m_fault);
        end
      end
    end
  endtask

  task automatic test_saturation;
    int e0;
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    e0 = n_early;
    repeat (300) gap(5);
    step(1'b0, 1'b0);
    total++;
    if (n_early - e0 != 300) begin
      bad++;
      $display("FAIL sat_pulses got=%0d exp=300", n_early - e0);
    end
    total++;
    if (bus.fault_cnt !== 8'd255) begin
      bad++;
      $display("FAIL sat_fault got=%0d exp=255", bus.fault_cnt);
    end
    total++;
    if (bus.locked !== 1'b0 || bus.last_period !== 4'd4) begin
      bad++;
      $display("FAIL sat_state got=%b/%0d exp=0/4",
               bus.locked, bus.last_period);
    end
  endtask

  task automatic test_exclusive;
    total++;
    if (n_both != 0) begin
      bad++;
      $display("FAIL excl got=%0d exp=0", n_both);
    end
  endtask

  initial begin
    clk     = 1'b0;
    rst     = 1'b1;
    bus.sig = 1'b0;
    total   = 0;
    bad     = 0;
    test_reset();
    test_nominal();
    test_window();
    test_late();
    test_reset_mid();
    test_random();
    test_saturation();
    test_exclusive();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/delay_monitor.md
# delay_monitor

Receiving end of the periodic delay pulse: watches a one-cycle `sig` strobe produced by the delay generator, which fires every N+1 cycles. It checks every inter-pulse interval against N ± TOL and reports early/late faults. It declares lock after LOCKN consecutive good intervals. It sits beside the generator in the safety+liveness benchmark set and gives formal properties a monitor-side target.

## Interface
- `N`, 7500: expected `cnt` value on which the next pulse arrives (period N+1 cycles)
- `CBITS`, 13: counter width; must satisfy 2^CBITS > N+TOL
- `TOL`, 2: accepted deviation in cycles, 0 ≤ TOL < N
- `LOCKN`, 4: consecutive good intervals needed for lock, ≥ 1
- `clk`  in  1  clock; all state updates on posedge
- `rst`  in  1  reset; synchronous and active-high
- `sig`  in  1  strobe from generator; one cycle high per period
- `locked`  out  1  high while LOCKN or more consecutive good intervals have been seen
- `early`  out  1  one-cycle pulse: strobe arrived with cnt < N−TOL
- `late`  out  1  one-cycle pulse: no strobe by cnt == N+TOL
- `err`  out  1  early | late, registered
- `last_period`  out  CBITS  cnt value sampled at the most recent accepted or early strobe
- `fault_cnt`  out  8  saturating count of faults since reset

## Operation
- States: SYNC (no anchor pulse yet) and CHECK (measuring the interval since the last anchor).
- `cnt` is internal, CBITS wide. It clears on every anchor and increments by 1 every cycle in CHECK.
- SYNC:
  - `cnt` holds 0.
  - `sig`=1 → CHECK with `cnt`<=0; no good interval is counted.
- CHECK, evaluated per edge on the current `cnt`:
  - `sig`=1, N−TOL ≤ cnt ≤ N+TOL → accepted. `cnt`<=0; `last_period`<=cnt; `good_cnt` increments, saturating at LOCKN.
  - `sig`=1, cnt < N−TOL → early fault. Re-anchor: `cnt`<=0, stay in CHECK. `last_period`<=cnt; `good_cnt`<=0.
  - `sig`=0, cnt == N+TOL → late fault. Go to SYNC; `cnt`<=0; `good_cnt`<=0. `last_period` is unchanged.
  - Otherwise `cnt`<=cnt+1.
- `locked` is registered and equals (`good_cnt` == LOCKN) after the update. It drops on the same edge that records any fault.
- `fault_cnt` increments on each early or late fault and saturates at 255.
- `early`, `late` and `err` are mutually consistent; early and late can never both be high.
- Arithmetic is unsigned. `cnt` never exceeds N+TOL, so it cannot wrap.

## Timing
- Reset values: state SYNC, `cnt` 0, `good_cnt` 0, `locked` 0, `early` 0, `late` 0, `err` 0, `last_period` 0, `fault_cnt` 0.
- All outputs are registered. A decision taken at edge t is visible in cycle t+1. Fault pulses last exactly one cycle.
- With a nominal generator, the first strobe anchors the monitor. `locked` rises in the cycle after the (LOCKN)th following strobe.
- `rst`=1 overrides `sig` on the same edge, including mid-interval. All registers return to their reset values and state goes to SYNC.
- A strobe on the same edge as the late condition cannot occur, since N+TOL lies inside the window; that strobe is accepted.
- Formal target: (F G !rst ∧ nominal `sig`) → F G `locked`, and G !(early ∧ late).

## Structure
- Package `delay_pkg`:
  - state enum `mon_state_t` {SYNC, CHECK};
  - localparam defaults for N, CBITS, TOL and LOCKN;
  - width-check function asserting 2^CBITS > N+TOL.
- Sub-module `sat_counter` (parameter WIDTH and MAX; ports inc, clr, q). It is instantiated for `good_cnt` and `fault_cnt`.
- FSM, window compare and output registers stay in `delay_monitor`.

## Test plan
All scenarios use N=10, TOL=1, LOCKN=2.

- **Nominal:** strobes every 11 cycles from cycle 5 → accepted with cnt=10. `locked` rises the cycle after the third strobe; `last_period`=10; `err` never asserts.
- **Window edges:** intervals giving cnt=9 and cnt=11 are accepted. cnt=8 gives an `early` pulse and `fault_cnt`=1, with `locked` dropping in the same cycle.
- **Late:** after lock, withhold the strobe → `late` pulses once, one cycle after cnt reaches 11. State returns to SYNC, `locked`=0, and the next strobe re-anchors without counting an interval.
- **Reset mid-interval:** `rst` at cnt=6 while `sig`=1 → all outputs return to reset values and no fault is recorded. A nominal strobe train relocks after 3 strobes.
- **Saturation:** 300 consecutive early strobes (period 5) → `fault_cnt` holds at 255, and `early` pulses on every strobe.
